// File: rtl/tb_result_checker.sv
// Clocked compare-side scoreboard: accepts (stimulus, generated, ref) samples during a run,
// counts matches and mismatches, captures the first mismatch and reports a verdict when done.
module tb_result_checker #(
   parameter int DATA_W    = 1,
   parameter int CNT_W     = 16,
   parameter int NUM_TESTS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [DATA_W-1:0] stim_in,
   input  logic [DATA_W-1:0] out_generated,
   input  logic [DATA_W-1:0] out_ref,
   output logic [CNT_W-1:0]  pass_count,
   output logic [CNT_W-1:0]  fail_count,
   output logic              done,
   output logic              all_passed,
   output logic              fail_seen,
   output logic [CNT_W-1:0]  first_fail_idx,
   output logic [DATA_W-1:0] first_fail_in,
   output logic [DATA_W-1:0] first_fail_gen,
   output logic [DATA_W-1:0] first_fail_ref
);

   // Handshake: a sample is taken on a rising edge where sample_valid && sample_ready;
   // sample_ready is high only in RUN, and samples offered outside RUN are discarded.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TESTS - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    pass_q, pass_d;
   logic [CNT_W-1:0]    fail_q, fail_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic                seen_q, seen_d;
   logic [CNT_W-1:0]    ff_idx_q, ff_idx_d;
   logic [DATA_W-1:0]   ff_in_q, ff_in_d;
   logic [DATA_W-1:0]   ff_gen_q, ff_gen_d;
   logic [DATA_W-1:0]   ff_ref_q, ff_ref_d;
   logic                match;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Case equality so that X/Z differences in the DUT output count as failures.
   assign match = (out_generated === out_ref);

   always_comb begin
      state_d  = state_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      idx_d    = idx_q;
      seen_d   = seen_q;
      ff_idx_d = ff_idx_q;
      ff_in_d  = ff_in_q;
      ff_gen_d = ff_gen_q;
      ff_ref_d = ff_ref_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = S_RUN;
               pass_d   = '0;
               fail_d   = '0;
               idx_d    = '0;
               seen_d   = 1'b0;
               ff_idx_d = '0;
               ff_in_d  = '0;
               ff_gen_d = '0;
               ff_ref_d = '0;
            end
         end
         S_RUN: begin
            if (sample_valid) begin
               idx_d = sat_inc(idx_q);
               if (match) begin
                  pass_d = sat_inc(pass_q);
               end else begin
                  fail_d = sat_inc(fail_q);
                  if (!seen_q) begin
                     seen_d   = 1'b1;
                     ff_idx_d = idx_q;
                     ff_in_d  = stim_in;
                     ff_gen_d = out_generated;
                     ff_ref_d = out_ref;
                  end
               end
               if (idx_q == LAST_IDX) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pass_q   <= '0;
         fail_q   <= '0;
         idx_q    <= '0;
         seen_q   <= 1'b0;
         ff_idx_q <= '0;
         ff_in_q  <= '0;
         ff_gen_q <= '0;
         ff_ref_q <= '0;
      end else begin
         state_q  <= state_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         idx_q    <= idx_d;
         seen_q   <= seen_d;
         ff_idx_q <= ff_idx_d;
         ff_in_q  <= ff_in_d;
         ff_gen_q <= ff_gen_d;
         ff_ref_q <= ff_ref_d;
      end
   end

   assign sample_ready   = (state_q == S_RUN);
   assign done           = (state_q == S_DONE);
   assign all_passed     = done && (fail_q == '0);
   assign pass_count     = pass_q;
   assign fail_count     = fail_q;
   assign fail_seen      = seen_q;
   assign first_fail_idx = ff_idx_q;
   assign first_fail_in  = ff_in_q;
   assign first_fail_gen = ff_gen_q;
   assign first_fail_ref = ff_ref_q;

endmodule
